// File: rtl/mmio_key_reader.sv
// Memory-mapped push-button reader: synchronized, debounced key levels and sticky press events.
// Optional macro KEY_IRQ_EN adds a registered irq output asserted while any press event is pending.
module mmio_key_reader #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [31:0]         daddr,
    input  logic                re,
    output logic [31:0]         dout,
    output logic                rvalid
`ifdef KEY_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int                 CW         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]      CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] REL_LVL   = {NUM_KEYS{KEY_ACTIVE_LOW}};
    localparam logic [15:0]        LEVEL_PAGE = 16'h8008;
    localparam logic [15:0]        EVENT_PAGE = 16'h800C;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] stable_q;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] event_q;
    logic [NUM_KEYS-1:0] event_d;
    logic [31:0]         dout_q;
    logic [31:0]         dout_d;
    logic                rvalid_q;
    logic                rvalid_d;
    logic [NUM_KEYS-1:0] samp_s;
    logic [NUM_KEYS-1:0] rise_s;
    logic                level_hit_s;
    logic                event_hit_s;
    logic                daddr_unused_s;

    // Released level maps to 0 after the XOR, so samp_s is 1 = pressed for either pin polarity.
    assign samp_s         = sync2_q ^ REL_LVL;
    assign level_hit_s    = re && (daddr[31:16] == LEVEL_PAGE);
    assign event_hit_s    = re && (daddr[31:16] == EVENT_PAGE);
    assign daddr_unused_s = ^daddr[15:0];

    // Per-key debounce: a new level must differ from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (samp_s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = samp_s[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise_s = stable_d & ~stable_q;

    // Read port and event latch; a press landing on an EVENT read survives the clear.
    always_comb begin
        dout_d   = dout_q;
        rvalid_d = 1'b0;
        event_d  = event_q | rise_s;
        if (level_hit_s) begin
            dout_d                 = 32'h0000_0000;
            dout_d[NUM_KEYS-1:0]   = stable_q;
            rvalid_d               = 1'b1;
        end else if (event_hit_s) begin
            dout_d                 = 32'h0000_0000;
            dout_d[NUM_KEYS-1:0]   = event_q;
            rvalid_d               = 1'b1;
            event_d                = rise_s;
        end else begin
            rvalid_d = 1'b0;
        end
    end

    // State registers; reset discards any debounce progress and any pending read response.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q  <= REL_LVL;
            sync2_q  <= REL_LVL;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            event_q  <= '0;
            dout_q   <= 32'h0000_0000;
            rvalid_q <= 1'b0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            event_q  <= event_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;

`ifdef KEY_IRQ_EN
    logic irq_q;

    // Interrupt follows the pending-event set one cycle late.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |event_q;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmio_key_reader.sv
// Directed self-checking bench for mmio_key_reader (NUM_KEYS=4, DEBOUNCE_CYCLES=4, active-low keys).
module tb_mmio_key_reader;

    localparam logic [31:0] LVL_A = 32'h8008_0000;
    localparam logic [31:0] EVT_A = 32'h800C_0000;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  key_in;
    logic [31:0] daddr;
    logic        re;
    logic [31:0] dout;
    logic        rvalid;
`ifdef KEY_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        re;
        logic [31:0] addr;
        logic        rv;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [9];

    mmio_key_reader #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_in  (key_in),
        .daddr   (daddr),
        .re      (re),
        .dout    (dout),
        .rvalid  (rvalid)
`ifdef KEY_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one bus cycle at a negedge, then check the response one edge later.
    task automatic cyc(input string nm, input logic r, input logic [31:0] a,
                       input logic exp_rv, input logic [31:0] exp_d);
        re    = r;
        daddr = a;
        @(negedge sys_clk);
        chk({nm, "_rvalid"}, {31'd0, rvalid}, {31'd0, exp_rv});
        chk({nm, "_dout"}, dout, exp_d);
    endtask

    task automatic idle(input int n);
        re    = 1'b0;
        daddr = 32'h0000_0000;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
`ifdef KEY_IRQ_EN
        chk(nm, {31'd0, irq}, {31'd0, exp});
`endif
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h8008_0000, 1'b1, 32'h2};
        tbl[1] = '{1'b1, 32'h8008_FFFC, 1'b1, 32'h2};
        tbl[2] = '{1'b0, 32'h800C_0000, 1'b0, 32'h2};
        tbl[3] = '{1'b1, 32'h800C_0000, 1'b1, 32'h2};
        tbl[4] = '{1'b1, 32'h800C_1234, 1'b1, 32'h0};
        tbl[5] = '{1'b1, 32'h8004_0000, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 32'h8008_0000, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 32'h8008_0010, 1'b1, 32'h2};
        tbl[8] = '{1'b1, 32'h0008_0000, 1'b0, 32'h2};

        sys_rst = 1'b1;
        key_in  = 4'hF;
        re      = 1'b0;
        daddr   = 32'h0000_0000;
        repeat (3) @(negedge sys_clk);
        chk("reset_dout", dout, 32'h0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'h0);
        chk_irq("reset_irq", 1'b0);
        sys_rst = 1'b0;

        cyc("reset_level", 1'b1, LVL_A, 1'b1, 32'h0);
        cyc("rvalid_pulse", 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);

        // Clean press on key1: stable rises on the 6th edge, visible on the 7th read.
        key_in[1] = 1'b0;
        re        = 1'b1;
        daddr     = LVL_A;
        for (int k = 1; k <= 7; k++) begin
            @(negedge sys_clk);
            chk($sformatf("press_rv%0d", k), {31'd0, rvalid}, 32'h1);
            chk($sformatf("press_lvl%0d", k), dout, (k == 7) ? 32'h2 : 32'h0);
            if (k == 6) chk_irq("press_irq_early", 1'b0);
            if (k == 7) chk_irq("press_irq", 1'b1);
        end

        for (int i = 0; i < 9; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].re, tbl[i].addr, tbl[i].rv, tbl[i].dout);
        end
        idle(2);
        chk_irq("irq_cleared", 1'b0);

        key_in = 4'hF;
        idle(10);
        cyc("release_evt", 1'b1, EVT_A, 1'b1, 32'h0);
        cyc("release_lvl", 1'b1, LVL_A, 1'b1, 32'h0);
        idle(1);

        // Bounce on key0: 2-cycle pulses never reach the 4-cycle threshold.
        re = 1'b0;
        for (int c = 0; c < 20; c++) begin
            key_in[0] = (((c / 2) % 2) == 0) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
        end
        key_in = 4'hF;
        idle(8);
        cyc("bounce_evt", 1'b1, EVT_A, 1'b1, 32'h0);
        cyc("bounce_lvl", 1'b1, LVL_A, 1'b1, 32'h0);
        idle(1);

        // Key2 stable rises on the same edge that samples an EVENT read.
        key_in[2] = 1'b0;
        idle(5);
        cyc("collide_read", 1'b1, EVT_A, 1'b1, 32'h0);
        chk_irq("collide_irq0", 1'b0);
        cyc("collide_next", 1'b1, EVT_A, 1'b1, 32'h4);
        chk_irq("collide_irq1", 1'b1);
        cyc("collide_hold", 1'b0, 32'h0, 1'b0, 32'h4);
        chk_irq("collide_irq_clr", 1'b0);

        // Reset in the middle of a read response and of a fresh debounce.
        key_in[3] = 1'b0;
        idle(8);
        cyc("both_lvl", 1'b1, LVL_A, 1'b1, 32'hC);
        re    = 1'b1;
        daddr = EVT_A;
        @(posedge sys_clk);
        #1;
        chk("midrd_rvalid", {31'd0, rvalid}, 32'h1);
        chk("midrd_dout", dout, 32'h8);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_dout", dout, 32'h0);
        re = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc("post_rst_lvl", 1'b1, LVL_A, 1'b1, 32'h0);
        idle(8);
        cyc("post_rst_evt", 1'b1, EVT_A, 1'b1, 32'hC);
        key_in = 4'hF;
        idle(10);
        cyc("final_lvl", 1'b1, LVL_A, 1'b1, 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
